cla_nibble_seq: RTL and testbench
=================================

Name: cla_nibble_seq

Overview:
Sequencer that reuses one 4-bit carry-lookahead adder to add two multi-nibble operands.
Operand nibble pairs arrive one per handshake on ui_in, LSB nibble first. Carry is chained through a register between nibbles, and sum nibbles are buffered. The result is then streamed out LSB first under a ready/ack handshake.
Top-level Tiny Tapeout tile. It replaces direct single-shot 4-bit adds.

Parameters:
NIBBLES, 4, operand width in nibbles (operand = 4*NIBBLES bits); legal range 2..8.
IDXW, $clog2(NIBBLES), nibble index width; derived, not overridden.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  reset, synchronous, active-low.
ena  input  1  tile enable, always 1 when powered; ignored.
ui_in  input  8  [3:0]=A nibble, [7:4]=B nibble.
uio_in  input  8  [0]=start, [1]=in_valid, [2]=cin, [3]=out_ack, [4]=abort, [7:5] unused.
uo_out  output  8  [3:0]=sum nibble, [4]=out_valid, [5]=cout, [6]=busy, [7]=done.
uio_out  output  8  constant 8'h00.
uio_oe  output  8  constant 8'h00 (all uio pins are inputs).

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, idx=0, carry_q=0, cout_q=0, done=0, sum buffer cleared. All uo_out bits read 0 in the cycle after reset.
- States: IDLE, LOAD, OUT. Encoded 2 bits; unused code returns to IDLE.
- IDLE: busy=0, out_valid=0.
  - start=1 → LOAD; carry_q<=cin; idx<=0; done<=0.
  - in_valid and out_ack are ignored in IDLE.
- LOAD: busy=1.
  - Each cycle with in_valid=1: {c,s}=cla4(A,B,carry_q); buf[idx]<=s; carry_q<=c; idx<=idx+1.
  - Cycles with in_valid=0 change nothing; gaps are allowed.
  - Throughput is one nibble pair per cycle.
  - On the beat where idx==NIBBLES-1: cout_q<=c; idx<=0; → OUT.
- OUT: busy=1, out_valid=1, uo_out[3:0]=buf[idx] (registered, no combinational path from inputs).
  - out_ack=1 → idx++.
  - On the ack where idx==NIBBLES-1: → IDLE; done<=1.
  - out_ack held high streams one nibble per cycle.
- cout (uo_out[5]) = cout_q. Valid in OUT and in IDLE while done=1; otherwise 0.
- done: sticky. Cleared by start, abort or reset.
- abort=1 in LOAD or OUT → IDLE next cycle; idx=0, done=0, out_valid=0. Buffer contents are don't-care.
  - abort has priority over in_valid/out_ack in the same cycle. abort in IDLE has no effect.
- start while in LOAD/OUT is ignored. start+abort together in IDLE → start wins (abort is a no-op in IDLE).
- Reset mid-operation returns to IDLE with all outputs cleared; there is no partial result.
- Arithmetic: modulo 2^(4*NIBBLES) sum; final carry on cout; cin is sampled only at start.
- Total latency: from start, NIBBLES valid beats, then NIBBLES ack beats; first sum nibble is visible the cycle after the last valid beat.

Decomposition:
- Shared package cla_seq_pkg:
  - state enum (IDLE/LOAD/OUT);
  - uio_in bit-index constants (START, IN_VALID, CIN, OUT_ACK, ABORT);
  - uo_out bit-index constants.
- One sub-module, cla4: purely combinational 4-bit carry-lookahead adder (a, b, cin → sum, cout) using P/G terms. Instantiated once.
- Controller, index counter, carry register and sum buffer live in cla_nibble_seq.

Test Plan:
- NIBBLES=4, cin=0, pairs (A,B) = (4,D),(3,C),(2,F),(1,0) on consecutive cycles → out nibbles 1,0,2,2 (0x2201), cout=0, done=1 after 4th ack.
- 0xFFFF+0x0001, cin=0, with in_valid low for 2 cycles between beats 2 and 3 → result 0x0000, cout=1; gaps do not disturb the result.
- 0x0000+0x0000, cin=1 → 0x0001, cout=0. cin changes after start → no effect.
- abort asserted on the 3rd LOAD beat together with in_valid → IDLE next cycle, busy=0, done=0. A new start then produces a correct fresh sum.
- rst_n=0 for one cycle while in OUT with out_ack held high → next cycle uo_out=8'h00. Subsequent start works normally.
- out_ack held continuously in OUT → 4 distinct nibbles on 4 consecutive cycles, then busy=0; uio_oe=0 and uio_out=0 throughout.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types and pin-map constants for the nibble-serial carry-lookahead adder tile.
// Both the controller and the bench use these bit indices.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // uio_in bit positions
  localparam int UI_START    = 0;
  localparam int UI_IN_VALID = 1;
  localparam int UI_CIN      = 2;
  localparam int UI_OUT_ACK  = 3;
  localparam int UI_ABORT    = 4;

  // uo_out bit positions
  localparam int UO_SUM_LSB   = 0;
  localparam int UO_OUT_VALID = 4;
  localparam int UO_COUT      = 5;
  localparam int UO_BUSY      = 6;
  localparam int UO_DONE      = 7;

  localparam int NIB_W = 4;

endpackage

// File: rtl/cla4.sv
// Combinational 4-bit carry-lookahead adder built from propagate/generate terms.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // All carries are flattened from cin so no bit waits on a ripple.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_nibble_seq.sv
// Tiny Tapeout tile: adds two NIBBLES-wide operands one nibble pair per beat through a
// single cla4, buffers the sum and streams it back out LSB nibble first.
//
// state   | meaning
// IDLE    | waiting for start; done/cout hold the last result
// LOAD    | accepting operand nibble pairs on in_valid, carry chained in carry_q
// OUT     | presenting sum_buf[idx], advancing on out_ack
module cla_nibble_seq
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int IDXW   = $clog2(NIBBLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic              carry_q;
  logic              cout_q;
  logic              done_q;
  logic [NIB_W-1:0]  sum_buf [NIBBLES];

  logic              start;
  logic              in_valid;
  logic              cin;
  logic              out_ack;
  logic              abort;
  logic              idx_last;

  logic [NIB_W-1:0]  cla_sum;
  logic              cla_cout;

  logic              unused_ok;

  assign start    = uio_in[UI_START];
  assign in_valid = uio_in[UI_IN_VALID];
  assign cin      = uio_in[UI_CIN];
  assign out_ack  = uio_in[UI_OUT_ACK];
  assign abort    = uio_in[UI_ABORT];
  assign idx_last = (idx == LAST_IDX);

  assign unused_ok = &{1'b0, ena, uio_in[7:5]};

  cla4 u_cla4 (
    .a    (ui_in[3:0]),
    .b    (ui_in[7:4]),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NIBBLES; i++) begin
        sum_buf[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          // abort is meaningless here, so start always wins
          if (start) begin
            state   <= ST_LOAD;
            carry_q <= cin;
            cout_q  <= 1'b0;
            idx     <= '0;
            done_q  <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (abort) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_q <= 1'b0;
          end else if (in_valid) begin
            sum_buf[idx] <= cla_sum;
            carry_q      <= cla_cout;
            if (idx_last) begin
              cout_q <= cla_cout;
              idx    <= '0;
              state  <= ST_OUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        ST_OUT: begin
          if (abort) begin
            state  <= ST_IDLE;
            idx    <= '0;
            done_q <= 1'b0;
          end else if (out_ack) begin
            if (idx_last) begin
              state  <= ST_IDLE;
              idx    <= '0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Outputs decode registers only; nothing from ui_in/uio_in reaches uo_out combinationally.
  logic in_out;
  assign in_out = (state == ST_OUT);

  always_comb begin
    uo_out                             = 8'h00;
    uo_out[UO_SUM_LSB +: NIB_W]        = in_out ? sum_buf[idx] : '0;
    uo_out[UO_OUT_VALID]               = in_out;
    uo_out[UO_COUT]                    = cout_q & (in_out | (done_q && state == ST_IDLE));
    uo_out[UO_BUSY]                    = (state != ST_IDLE);
    uo_out[UO_DONE]                    = done_q;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Directed bench for cla_nibble_seq (NIBBLES=4): table of add vectors plus abort/reset sequences.
module tb_cla_nibble_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests;
  int failures;

  cla_nibble_seq #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    int          gap_after;
    int          gap_len;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uio_in encodings
  function automatic logic [7:0] uio(input logic start, input logic in_valid, input logic cin,
                                     input logic ack, input logic abort);
    return {3'b000, abort, ack, cin, in_valid, start};
  endfunction

  task automatic feed_beats(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input int gap_after, input int gap_len, input string tag);
    for (int i = 0; i < 4; i++) begin
      ui_in  = {b[4*i +: 4], a[4*i +: 4]};
      // cin deliberately inverted after start: it must not matter any more
      uio_in = uio(1'b0, 1'b1, ~cin, 1'b0, 1'b0);
      tick();
      if (i < 3) check({tag, " out_valid_in_load"}, 32'(uo_out[4]), 32'd0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          ui_in  = 8'hA5;
          uio_in = uio(1'b0, 1'b0, ~cin, 1'b0, 1'b0);
          tick();
          check({tag, " busy_in_gap"}, 32'(uo_out[6]), 32'd1);
        end
      end
    end
    uio_in = 8'h00;
  endtask

  task automatic run_add(input vec_t v, input string tag);
    logic [15:0] got;
    got    = 16'h0;
    ui_in  = 8'h00;
    uio_in = uio(1'b1, 1'b0, v.cin, 1'b0, 1'b0);
    tick();
    check({tag, " busy_after_start"}, 32'(uo_out[6]), 32'd1);
    check({tag, " done_cleared"}, 32'(uo_out[7]), 32'd0);
    feed_beats(v.a, v.b, v.cin, v.gap_after, v.gap_len, tag);
    check({tag, " out_valid_first"}, 32'(uo_out[4]), 32'd1);
    check({tag, " cout_in_out"}, 32'(uo_out[5]), 32'(v.cout));
    for (int i = 0; i < 4; i++) begin
      got[4*i +: 4] = uo_out[3:0];
      check({tag, " out_valid_stream"}, 32'(uo_out[4]), 32'd1);
      check({tag, " uio_const"}, 32'({uio_oe, uio_out}), 32'd0);
      uio_in = uio(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    uio_in = 8'h00;
    check({tag, " sum"}, 32'(got), 32'(v.sum));
    check({tag, " cout_idle"}, 32'(uo_out[5]), 32'(v.cout));
    check({tag, " busy_end"}, 32'(uo_out[6]), 32'd0);
    check({tag, " done_end"}, 32'(uo_out[7]), 32'd1);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    rst_n    = 1'b0;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, -1, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1,  1, 2};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, -1, 0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1,  0, 1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, -1, 0};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0,  2, 3};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, -1, 0};
    vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, -1, 0};

    tick();
    tick();
    check("reset_uo_out", 32'(uo_out), 32'h00);
    rst_n = 1'b1;
    tick();
    check("post_reset_uo_out", 32'(uo_out), 32'h00);
    check("post_reset_uio", 32'({uio_oe, uio_out}), 32'd0);

    // in_valid/out_ack ignored in IDLE
    uio_in = uio(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("idle_ignore", 32'(uo_out), 32'h00);

    for (int k = 0; k < 8; k++) begin
      run_add(vecs[k], $sformatf("vec%0d", k));
    end

    // in_valid/out_ack/abort in IDLE with done set leave the result alone
    uio_in = uio(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("idle_abort_done", 32'(uo_out[7]), 32'd1);
    check("idle_abort_busy", 32'(uo_out[6]), 32'd0);

    // abort on third LOAD beat together with in_valid
    uio_in = uio(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("start_beats_abort", 32'(uo_out[6]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      ui_in  = 8'h11;
      uio_in = uio(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    ui_in  = 8'h11;
    uio_in = uio(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    uio_in = 8'h00;
    check("abort_load_busy", 32'(uo_out[6]), 32'd0);
    check("abort_load_done", 32'(uo_out[7]), 32'd0);
    check("abort_load_valid", 32'(uo_out[4]), 32'd0);
    run_add(vecs[5], "after_abort");

    // abort in OUT with out_ack also high
    uio_in = uio(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    feed_beats(16'h1111, 16'h2222, 1'b0, -1, 0, "abort_out");
    uio_in = uio(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    uio_in = 8'h00;
    check("abort_out_uo", 32'(uo_out), 32'h00);

    // start in LOAD is ignored (index must not restart)
    uio_in = uio(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    ui_in  = 8'h21;
    uio_in = uio(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    uio_in = uio(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      ui_in  = 8'h00;
      uio_in = uio(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    uio_in = 8'h00;
    check("start_in_load_nib0", 32'(uo_out[4:0]), 32'h13);
    // reset while in OUT with out_ack held high
    uio_in = uio(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("reset_in_out_uo", 32'(uo_out), 32'h00);
    rst_n  = 1'b1;
    uio_in = 8'h00;
    tick();
    check("reset_release_uo", 32'(uo_out), 32'h00);
    run_add(vecs[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
